banco_reg_writeback: RTL and testbench
======================================

Name: banco_reg_writeback

Overview:
- Register-file and write-back stage of the multicycle MIPS datapath.
- Sits directly downstream of the control FSM and consumes its RegWrite, WriteRegMux, WriteDataMux, Load_A and Load_B strobes.
- Holds 32 general registers and the A/B operand latches that feed the ULA.
- Selects the write-back destination (rd/rt/ra/sp) and the write-back source (ULAOut, MDR, PC, LUI immediate, shifted value).

Parameters:
- DATA_W, 32, register and bus width.
- SP_INIT, 227, reset value of register 29 (stack pointer).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- RegWrite  in  1  write-enable strobe from the controller.
- WriteRegMux  in  3  destination select: 0=rd, 1=rt, 2=reg 31, 3=reg 29; 4..7 illegal.
- WriteDataMux  in  5  data select: 0=ULAOut, 1=MDR, 2=PC, 3={imm,16'b0}, 4=B<<shamt; 5..31 illegal.
- Load_A  in  1  latch rs read value into A.
- Load_B  in  1  latch rt read value into B.
- rs  in  5  IR[25:21].
- rt  in  5  IR[20:16].
- rd  in  5  IR[15:11].
- shamt  in  5  IR[10:6].
- imm  in  16  IR[15:0].
- ULAOut  in  DATA_W  ULA output register.
- MDR  in  DATA_W  memory data register.
- PC  in  DATA_W  program counter.
- A  out  DATA_W  operand latch A.
- B  out  DATA_W  operand latch B.
- dbg_sel  in  5  debug read address.
- dbg_data  out  DATA_W  combinational read of register[dbg_sel].
- sel_err  out  1  sticky illegal-select flag.
- wr_count  out  16  count of committed writes.

Behaviour:
- Reset (asynchronous, active-high), while asserted and immediately on assertion:
  - all registers cleared to 0, except reg 29 = SP_INIT;
  - A=0, B=0, sel_err=0, wr_count=0.
  - Reset asserted mid-operation discards any write in that cycle.
  - Release is sampled at the next rising edge.
- Write port:
  - On a rising edge with RegWrite=1, a legal destination and a legal data select: reg[dest] <= data.
  - Destination 0 is never written. Attempts to write it still count in wr_count; reg 0 always reads 0.
  - Illegal WriteRegMux or WriteDataMux with RegWrite=1: no register write, no count, sel_err <= 1.
  - sel_err stays set until reset.
  - Selects are ignored when RegWrite=0. Illegal values then do not set sel_err.
- Data select rules:
  - 3 gives imm in bits [31:16], zeros in [15:0].
  - 4 gives the current B latch shifted left logically by shamt (0..31); bits shifted out are lost.
- wr_count:
  - +1 per committed legal write, including writes aimed at reg 0.
  - Wraps from 0xFFFF to 0x0000.
- Operand latches:
  - Load_A=1 at an edge: A <= reg[rs]. Load_B=1 at an edge: B <= reg[rt].
  - A and B hold their value otherwise.
  - Both may load in the same cycle.
- Same-cycle write and read (write-first bypass): if a committed write targets rs (or rt), A (or B) loads the new write data, not the old contents.
  - No bypass when the target is reg 0; A/B then load 0.
- Shift source with Load_B in the same edge: the shift uses the B value from before the edge.
- Latency:
  - Written data is visible on dbg_data the cycle after the write edge.
  - A/B update one edge after Load_A/Load_B.
- dbg_data is purely combinational; reg 0 reads 0.

Test Plan:
1. Reset then release: reg29=227 and every other register 0 via dbg_sel sweep; A=B=0; wr_count=0; sel_err=0.
2. ULAOut=0x0000_0005, rd=8, WriteRegMux=0, WriteDataMux=0, RegWrite pulse -> reg8=5 next cycle, wr_count=1. Then rs=8, Load_A -> A=5.
3. rt=9, WriteRegMux=1, WriteDataMux=3, imm=0x1234 -> reg9=0x1234_0000. Same edge with Load_B, rt=9 -> B=0x1234_0000 (bypass).
4. WriteRegMux=2, WriteDataMux=2, PC=0x40 -> reg31=0x40. Then rd=0 write of 0xFFFF_FFFF -> reg0 reads 0, wr_count still increments.
5. B=0x0000_0003, shamt=4, WriteDataMux=4, rd=10 -> reg10=0x30. Then WriteRegMux=5 with RegWrite=1 -> no write, sel_err=1 and held. WriteDataMux=7 with RegWrite=0 -> no change.
6. Assert reset asynchronously mid-cycle during a RegWrite pulse to reg 8 -> reg8=0, wr_count=0 immediately, no write after release.

Source files
------------

// File: rtl/banco_reg_writeback_if.sv
// banco_reg_writeback_if
// ----------------------
// Bundles the controller strobes, instruction fields, write-back sources and
// observable outputs of the register-file / write-back stage.
//
// Signal timing: there is no valid/ready handshake on this bus. Every input
// is a level that the register file samples on the rising clock edge.
// RegWrite, Load_A and Load_B each act for exactly the edge at which they
// are high. The outputs A, B, sel_err and wr_count are registered.
// dbg_data is a combinational read.
//
// Modports:
//   master - the controller/datapath side: drives the strobes and data, reads results
//   slave  - the register file: consumes the strobes, drives A/B/debug/status
//
// DATA_W must match the DATA_W of the banco_reg_writeback instance.
interface banco_reg_writeback_if #(
  parameter int DATA_W = 32
);
  logic              RegWrite;
  logic [2:0]        WriteRegMux;
  logic [4:0]        WriteDataMux;
  logic              Load_A;
  logic              Load_B;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] ULAOut;
  logic [DATA_W-1:0] MDR;
  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [4:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic              sel_err;
  logic [15:0]       wr_count;

  modport master (
    output RegWrite, WriteRegMux, WriteDataMux, Load_A, Load_B,
    output rs, rt, rd, shamt, imm, ULAOut, MDR, PC, dbg_sel,
    input  A, B, dbg_data, sel_err, wr_count
  );

  modport slave (
    input  RegWrite, WriteRegMux, WriteDataMux, Load_A, Load_B,
    input  rs, rt, rd, shamt, imm, ULAOut, MDR, PC, dbg_sel,
    output A, B, dbg_data, sel_err, wr_count
  );
endinterface

// File: rtl/banco_reg_writeback.sv
// banco_reg_writeback
// -------------------
// This module is the register file and write-back stage of the multicycle
// MIPS datapath. It holds the 32 general registers and the A/B operand
// latches that feed the ULA.
//
// It selects the write-back destination:
//   rd / rt / reg 31 / reg 29
// It selects the write-back source:
//   ULAOut / MDR / PC / {imm,16'b0} / B<<shamt
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset. Clears every register except
//            reg 29, which takes SP_INIT. Also clears A, B, sel_err and wr_count.
//   bus    - banco_reg_writeback_if.slave. It carries the strobes, the IR
//            fields, the sources and the outputs A, B, dbg_data, sel_err and
//            wr_count.
//
// A write commits on an edge only when RegWrite is high and both selects are
// legal. Reg 0 is never stored, but a write aimed at it still counts. An
// illegal select while RegWrite is high sets the sticky sel_err flag instead.
module banco_reg_writeback #(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = 227
) (
  input  logic                  clk,
  input  logic                  reset,
  banco_reg_writeback_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              sel_err_q, sel_err_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [4:0]        dest;
  logic              dest_ok;
  logic [DATA_W-1:0] wdata;
  logic              data_ok;
  logic              commit;

  // Destination decode
  always_comb begin
    dest    = 5'd0;
    dest_ok = 1'b1;
    case (bus.WriteRegMux)
      3'd0:    dest = bus.rd;
      3'd1:    dest = bus.rt;
      3'd2:    dest = 5'd31;
      3'd3:    dest = 5'd29;
      default: dest_ok = 1'b0;
    endcase
  end

  // Source decode. The shift uses b_q, the B value from before the edge,
  // even if Load_B also fires at this edge.
  always_comb begin
    wdata   = '0;
    data_ok = 1'b1;
    case (bus.WriteDataMux)
      5'd0:    wdata = bus.ULAOut;
      5'd1:    wdata = bus.MDR;
      5'd2:    wdata = bus.PC;
      5'd3:    wdata[DATA_W-1 -: 16] = bus.imm;
      5'd4:    wdata = b_q << bus.shamt;
      default: data_ok = 1'b0;
    endcase
  end

  assign commit = bus.RegWrite & dest_ok & data_ok;

  // Next state. regs_d already holds this cycle's write, so reading it for
  // A/B gives write-first bypass for free. Reg 0 is never written, so it
  // reads 0 whether or not it is the write target.
  always_comb begin
    regs_d = regs_q;
    if (commit && dest != 5'd0) begin
      regs_d[dest] = wdata;
    end
    a_d        = bus.Load_A ? regs_d[bus.rs] : a_q;
    b_d        = bus.Load_B ? regs_d[bus.rt] : b_q;
    sel_err_d  = sel_err_q | (bus.RegWrite & ~(dest_ok & data_ok));
    wr_count_d = wr_count_q + {15'd0, commit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 29) ? DATA_W'(SP_INIT) : '0;
      end
      a_q        <= '0;
      b_q        <= '0;
      sel_err_q  <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      regs_q[0]  <= '0;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_err_q  <= sel_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.sel_err  = sel_err_q;
  assign bus.wr_count = wr_count_q;
  assign bus.dbg_data = (bus.dbg_sel == 5'd0) ? '0 : regs_q[bus.dbg_sel];

endmodule

// File: tb/tb_banco_reg_writeback.sv
// Self-checking bench for banco_reg_writeback. Uses directed steps from the
// test plan plus randomized cycles checked against a behavioural model.
module tb_banco_reg_writeback;

  logic clk;
  logic reset;
  banco_reg_writeback_if #(.DATA_W(32)) bus ();

  banco_reg_writeback #(.DATA_W(32), .SP_INIT(227)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_a, m_b;
  logic        m_err;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
    m_a = 0; m_b = 0; m_err = 0; m_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge and predicts the result from the
  // write-back rules. It checks A, B, sel_err, wr_count and
  // register[dsel] just after the next rising edge.
  task automatic step(input logic rw, input logic [2:0] wrm, input logic [4:0] wdm,
                      input logic la, input logic lb,
                      input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
                      input logic [4:0] sh_i, input logic [15:0] imm_i,
                      input logic [31:0] ula_i, input logic [31:0] mdr_i, input logic [31:0] pc_i,
                      input logic [4:0] dsel);
    int          dest;
    logic [31:0] wd;
    logic        ok;
    logic [31:0] na, nb;
    @(negedge clk);
    bus.RegWrite = rw; bus.WriteRegMux = wrm; bus.WriteDataMux = wdm;
    bus.Load_A = la; bus.Load_B = lb;
    bus.rs = rs_i; bus.rt = rt_i; bus.rd = rd_i; bus.shamt = sh_i; bus.imm = imm_i;
    bus.ULAOut = ula_i; bus.MDR = mdr_i; bus.PC = pc_i; bus.dbg_sel = dsel;

    dest = (wrm == 0) ? int'(rd_i) : (wrm == 1) ? int'(rt_i) : (wrm == 2) ? 31 : 29;
    case (wdm)
      5'd0: wd = ula_i;
      5'd1: wd = mdr_i;
      5'd2: wd = pc_i;
      5'd3: wd = {imm_i, 16'h0000};
      5'd4: wd = m_b << sh_i;
      default: wd = 32'd0;
    endcase
    ok = rw && (wrm <= 3) && (wdm <= 4);
    na = !la ? m_a : (ok && dest == int'(rs_i) && rs_i != 0) ? wd : m_regs[rs_i];
    nb = !lb ? m_b : (ok && dest == int'(rt_i) && rt_i != 0) ? wd : m_regs[rt_i];
    if (rw && !ok) m_err = 1'b1;
    if (ok) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (dest != 0) m_regs[dest] = wd;
    end
    m_a = na; m_b = nb;
    exp_q.push_back(m_a);
    exp_q.push_back(m_b);
    exp_q.push_back({31'd0, m_err});
    exp_q.push_back(32'(m_cnt));
    exp_q.push_back(dsel == 0 ? 32'd0 : m_regs[dsel]);

    @(posedge clk); #1;
    check("A",        bus.A,                 exp_q.pop_front());
    check("B",        bus.B,                 exp_q.pop_front());
    check("sel_err",  {31'd0, bus.sel_err},  exp_q.pop_front());
    check("wr_count", {16'd0, bus.wr_count}, exp_q.pop_front());
    check("dbg_data", bus.dbg_data,          exp_q.pop_front());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    bus.dbg_sel = r;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  task automatic rand_step(input bit allow_illegal);
    logic        rw;
    logic [2:0]  wrm;
    logic [4:0]  wdm, rs_i, rd_i;
    rw   = 1'($urandom_range(0, 1));
    wrm  = 3'($urandom_range(0, 3));
    wdm  = 5'($urandom_range(0, 4));
    rd_i = 5'($urandom_range(0, 31));
    rs_i = ($urandom_range(0, 3) == 0) ? rd_i : 5'($urandom_range(0, 31));
    if ((allow_illegal || !rw) && $urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 0) wrm = 3'($urandom_range(4, 7));
      else                           wdm = 5'($urandom_range(5, 31));
    end
    step(rw, wrm, wdm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         rs_i, ($urandom_range(0, 3) == 0) ? rd_i : 5'($urandom_range(0, 31)), rd_i,
         5'($urandom_range(0, 31)), 16'($urandom), $urandom, $urandom, $urandom,
         5'($urandom_range(0, 31)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.RegWrite = 0; bus.WriteRegMux = 0; bus.WriteDataMux = 0;
    bus.Load_A = 0; bus.Load_B = 0; bus.rs = 0; bus.rt = 0; bus.rd = 0;
    bus.shamt = 0; bus.imm = 0; bus.ULAOut = 0; bus.MDR = 0; bus.PC = 0; bus.dbg_sel = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: reset state
    check("rst_A", bus.A, 32'd0);
    check("rst_B", bus.B, 32'd0);
    check("rst_cnt", {16'd0, bus.wr_count}, 32'd0);
    check("rst_err", {31'd0, bus.sel_err}, 32'd0);
    for (int i = 0; i < 32; i++) check_reg("rst_reg", 5'(i), (i == 29) ? 32'd227 : 32'd0);

    // 2: ULAOut -> rd=8, then A <= reg8
    step(1, 0, 0, 0, 0, 0, 0, 8, 0, 16'h0, 32'h5, 0, 0, 8);
    check_reg("reg8", 8, 32'h5);
    check("cnt1", {16'd0, bus.wr_count}, 32'd1);
    step(0, 0, 0, 1, 0, 8, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    check("A_reg8", bus.A, 32'h5);

    // 3: LUI to rt=9 with same-edge Load_B bypass
    step(1, 1, 3, 0, 1, 0, 9, 0, 0, 16'h1234, 0, 0, 0, 9);
    check_reg("reg9", 9, 32'h1234_0000);
    check("B_bypass", bus.B, 32'h1234_0000);

    // 4: PC -> reg31, then write to reg0
    step(1, 2, 2, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 32'h40, 31);
    check_reg("reg31", 31, 32'h40);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, 32'hFFFF_FFFF, 0, 0, 0);
    check_reg("reg0", 0, 32'd0);
    check("A_reg0", bus.A, 32'd0);
    check("cnt_reg0", {16'd0, bus.wr_count}, 32'd4);

    // 5: shift source, B=3, shamt=4 -> 0x30
    step(1, 0, 0, 0, 0, 0, 0, 11, 0, 16'h0, 32'h3, 0, 0, 11);
    step(0, 0, 0, 0, 1, 0, 11, 0, 0, 16'h0, 0, 0, 0, 0);
    check("B_eq3", bus.B, 32'h3);
    // Shift with Load_B at the same edge uses the old B (3).
    step(1, 0, 4, 0, 1, 0, 31, 10, 5'd4, 16'h0, 0, 0, 0, 10);
    check_reg("reg10_shift", 10, 32'h30);
    check("B_after", bus.B, 32'h40);

    // Random legal phase: illegal selects only appear with RegWrite low.
    repeat (300) rand_step(0);
    check("err_clean", {31'd0, bus.sel_err}, 32'd0);

    // Illegal destination and illegal data select
    step(1, 5, 0, 0, 0, 0, 0, 12, 0, 16'h0, 32'hABCD, 0, 0, 12);
    check("err_set", {31'd0, bus.sel_err}, 32'd1);
    step(0, 0, 7, 0, 0, 0, 0, 12, 0, 16'h0, 32'h1111, 0, 0, 12);
    check("err_held", {31'd0, bus.sel_err}, 32'd1);
    step(1, 0, 9, 0, 0, 0, 0, 12, 0, 16'h0, 32'h2222, 0, 0, 12);

    // Random phase including illegal selects
    repeat (300) rand_step(1);

    // 6: asynchronous reset mid-cycle during a write to reg 8
    step(1, 0, 0, 1, 1, 8, 8, 8, 0, 16'h0, 32'h77, 0, 0, 8);
    @(negedge clk);
    bus.RegWrite = 1; bus.WriteRegMux = 0; bus.WriteDataMux = 0;
    bus.Load_A = 1; bus.Load_B = 1; bus.rs = 8; bus.rt = 8;
    bus.rd = 8; bus.ULAOut = 32'hDEAD_BEEF; bus.dbg_sel = 8;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_reg8", bus.dbg_data, 32'd0);
    check("arst_cnt", {16'd0, bus.wr_count}, 32'd0);
    check("arst_A", bus.A, 32'd0);
    check("arst_err", {31'd0, bus.sel_err}, 32'd0);
    check_reg("arst_reg29", 29, 32'd227);
    @(posedge clk); #1;
    check_reg("arst_hold8", 8, 32'd0);
    @(negedge clk);
    bus.RegWrite = 0; bus.Load_A = 0; bus.Load_B = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reg("post_reg8", 8, 32'd0);
    check("post_cnt", {16'd0, bus.wr_count}, 32'd0);
    repeat (50) rand_step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
